// File: rtl/pie_pkg.sv
// pie_pkg: shared state encoding, default PIE timing and parameter sanity check
package pie_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_DELIM, S_D0_HI, S_D0_LO, S_RT_HI, S_RT_LO,
    S_TR_HI, S_TR_LO, S_DAT_HI, S_DAT_LO, S_DONE
  } pie_state_t;

  localparam int PIE_CNT_W = 16;
  localparam int PIE_DELIM = 24;
  localparam int PIE_TARI  = 24;
  localparam int PIE_DATA1 = 42;
  localparam int PIE_PW    = 12;
  localparam int PIE_RTCAL = 66;
  localparam int PIE_TRCAL = 132;

  // True when every phase length is representable and the PIE ordering rules hold
  function automatic bit pie_timing_ok(input int cnt_w, input int delim, input int tari,
                                       input int data1, input int pw, input int rtcal,
                                       input int trcal);
    longint lim;
    lim = longint'(1) << cnt_w;
    return cnt_w > 0 && cnt_w < 32 && delim > 0 && pw > 0 && pw < tari &&
           tari < data1 && data1 <= 2 * tari && rtcal == tari + data1 &&
           rtcal < trcal && longint'(delim) < lim && longint'(trcal) < lim;
  endfunction

endpackage

// File: rtl/pie_phase_timer.sv
// pie_phase_timer: loadable down-counter that times one carrier phase
module pie_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over counting; the counter parks at zero once a phase expires
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

  assign o_zero = r_cnt == '0;

endmodule

// File: rtl/pie_symbol_encoder.sv
// pie_symbol_encoder: reader-side PIE transmitter (delimiter, preamble, data symbols)
import pie_pkg::*;

module pie_symbol_encoder #(
  parameter int CNT_W = PIE_CNT_W,
  parameter int DELIM = PIE_DELIM,
  parameter int TARI  = PIE_TARI,
  parameter int DATA1 = PIE_DATA1,
  parameter int PW    = PIE_PW,
  parameter int RTCAL = PIE_RTCAL,
  parameter int TRCAL = PIE_TRCAL
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic preamble,
  input  logic bit_in,
  input  logic bit_last,
  input  logic bit_valid,
  output logic bit_ready,
  output logic pie_out,
  output logic busy,
  output logic done,
  output logic underrun
);

  if (!pie_timing_ok(CNT_W, DELIM, TARI, DATA1, PW, RTCAL, TRCAL)) begin : g_bad_timing
    $error("pie_symbol_encoder: inconsistent timing parameters");
  end

  // Counter load values are phase length minus one: a phase ends when the counter reads zero
  localparam logic [CNT_W-1:0] L_DELIM = CNT_W'(DELIM - 1);
  localparam logic [CNT_W-1:0] L_D0_HI = CNT_W'(TARI - PW - 1);
  localparam logic [CNT_W-1:0] L_D1_HI = CNT_W'(DATA1 - PW - 1);
  localparam logic [CNT_W-1:0] L_RT_HI = CNT_W'(RTCAL - PW - 1);
  localparam logic [CNT_W-1:0] L_TR_HI = CNT_W'(TRCAL - PW - 1);
  localparam logic [CNT_W-1:0] L_PW    = CNT_W'(PW - 1);

  pie_state_t       r_state, w_next;
  logic             r_pre, r_last, r_pie, r_busy, r_done, r_underrun;
  logic             w_zero, w_ready, w_xfer, w_load;
  logic [CNT_W-1:0] w_load_val;

  pie_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (1'b1),
    .o_zero     (w_zero)
  );

  assign w_ready = w_zero && ((r_state == S_RT_LO && !r_pre) || r_state == S_TR_LO ||
                              (r_state == S_DAT_LO && !r_last));
  assign w_xfer  = w_ready && bit_valid;

  // Phase sequencing: each timed phase advances when its counter expires
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_DELIM : S_IDLE;
      S_DELIM:  w_next = w_zero ? S_D0_HI : S_DELIM;
      S_D0_HI:  w_next = w_zero ? S_D0_LO : S_D0_HI;
      S_D0_LO:  w_next = w_zero ? S_RT_HI : S_D0_LO;
      S_RT_HI:  w_next = w_zero ? S_RT_LO : S_RT_HI;
      S_RT_LO:  w_next = !w_zero ? S_RT_LO : r_pre ? S_TR_HI : w_xfer ? S_DAT_HI : S_IDLE;
      S_TR_HI:  w_next = w_zero ? S_TR_LO : S_TR_HI;
      S_TR_LO:  w_next = !w_zero ? S_TR_LO : w_xfer ? S_DAT_HI : S_IDLE;
      S_DAT_HI: w_next = w_zero ? S_DAT_LO : S_DAT_HI;
      S_DAT_LO: w_next = !w_zero ? S_DAT_LO : r_last ? S_DONE : w_xfer ? S_DAT_HI : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Every state change starts a fresh phase; entry into DAT_HI always coincides with a transfer
  assign w_load     = w_next != r_state;
  assign w_load_val = w_next == S_DELIM  ? L_DELIM :
                      w_next == S_D0_HI  ? L_D0_HI :
                      w_next == S_RT_HI  ? L_RT_HI :
                      w_next == S_TR_HI  ? L_TR_HI :
                      w_next == S_DAT_HI ? (bit_in ? L_D1_HI : L_D0_HI) :
                      (w_next inside {S_D0_LO, S_RT_LO, S_TR_LO, S_DAT_LO}) ? L_PW : '0;

  // State plus registered outputs, all derived from the upcoming state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= S_IDLE;
      r_pre      <= 1'b0;
      r_last     <= 1'b0;
      r_pie      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      if (r_state == S_IDLE && start) r_pre <= preamble;
      if (w_xfer) r_last <= bit_last;
      r_pie      <= !(w_next inside {S_DELIM, S_D0_LO, S_RT_LO, S_TR_LO, S_DAT_LO});
      r_busy     <= w_next != S_IDLE;
      r_done     <= w_next == S_DONE;
      r_underrun <= w_ready && !bit_valid;
    end

  assign bit_ready = w_ready;
  assign pie_out   = r_pie;
  assign busy      = r_busy;
  assign done      = r_done;
  assign underrun  = r_underrun;

endmodule

// File: doc/pie_symbol_encoder.md
Name: pie_symbol_encoder

Overview:
- Reader-side (interrogator) PIE transmitter: the forward-link counterpart of the tag's pulse-width measuring receive path.
- Turns a framed stream of command bits into a carrier-keyed baseband signal.
- Output timing is carrier-high/low phases of exact cycle counts: delimiter, data-0, RTcal, optional TRcal, then PIE data symbols.
- Sits between the reader command formatter (bit source) and the modulator driver in the bench/reader model used to exercise the tag.

Parameters:
- CNT_W, 16, width of the phase down-counter; every duration parameter must be < 2^CNT_W.
- DELIM, 24, delimiter low time in clk cycles.
- TARI, 24, data-0 symbol length in cycles.
- DATA1, 42, data-1 symbol length in cycles; must satisfy TARI < DATA1 <= 2*TARI.
- PW, 12, low-pulse width ending every symbol; must satisfy 0 < PW < TARI.
- RTCAL, 66, RTcal symbol length; must equal TARI+DATA1.
- TRCAL, 132, TRcal symbol length; must satisfy RTCAL < TRCAL.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- preamble  in  1  sampled with start: 1 = full preamble (includes TRcal), 0 = frame-sync (no TRcal)
- bit_in  in  1  data bit
- bit_last  in  1  qualifies bit_in as the final bit of the frame
- bit_valid  in  1  source has a bit
- bit_ready  out  1  encoder accepts a bit this cycle; transfer = bit_valid & bit_ready
- pie_out  out  1  1 = carrier on, 0 = carrier off; registered
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse after the last symbol's low phase
- underrun  out  1  one-cycle pulse when a frame aborts for lack of data

Behaviour:
- Reset values: pie_out=1, busy=0, done=0, underrun=0, bit_ready=0. Internal state is IDLE and the counter is 0.
- Reset mid-frame returns immediately to these values. No partial symbol is completed.
- States: IDLE, DELIM, D0_HI, D0_LO, RT_HI, RT_LO, TR_HI, TR_LO, DAT_HI, DAT_LO, DONE.
- IDLE:
  - pie_out=1.
  - start=1 -> DELIM. pie_out is 0 from the next cycle. preamble is latched.
  - start while not in IDLE is ignored.
- Each phase holds pie_out constant for exactly its programmed count. The counter loads N-1 on entry and advances at 0.
  - DELIM: low, DELIM cycles.
  - D0: high TARI-PW, then low PW.
  - RT: high RTCAL-PW, then low PW.
  - TR (only if preamble latched): high TRCAL-PW, then low PW.
  - DAT: high (bit ? DATA1 : TARI)-PW, then low PW.
- bit_ready is asserted only in the final cycle of RT_LO (frame-sync case), TR_LO (preamble case), or DAT_LO whose current bit is not last.
  - Transfer in that cycle -> DAT_HI next cycle with the new bit.
  - No transfer -> underrun: pulse underrun, pie_out=1 next cycle, go to IDLE. busy falls; done is not pulsed.
- Final cycle of DAT_LO with last bit -> DONE. DONE lasts one cycle: pie_out=1, done=1. Then IDLE, busy=0.
- A new start is accepted the cycle after DONE at the earliest.
- Frame-sync frame with n bits: pie_out low-to-high pattern spans DELIM + TARI + RTCAL + Σ symbol lengths cycles. Preamble adds TRCAL.
- Zero-bit frames are not supported. The source must present at least one bit.
- Arithmetic is unsigned CNT_W. Lengths are computed from parameters at elaboration; no runtime wrap is possible given the parameter constraints.

Decomposition:
- Shared package pie_pkg holds:
  - state enum type;
  - default timing constants;
  - elaboration-time checks of the parameter constraints.
- Sub-module pie_phase_timer:
  - load value, down-count enable, zero flag;
  - counter of CNT_W bits;
  - async active-high reset to 0.

Test Plan:
- Frame-sync, single bit 0, last -> pie_out: 24 low, 12 high, 12 low, 54 high, 12 low, 12 high, 12 low. done pulses on the next cycle. busy high for 138 cycles plus the DONE cycle.
- Preamble, bits 1,0 (0 last) -> after DELIM/D0/RT, TR gives 120 high, 12 low. Then 30 high, 12 low, 12 high, 12 low, then done.
- Withhold bit_valid at the RTcal boundary -> underrun pulses exactly once, pie_out=1 next cycle, no done, busy=0. Next start is accepted normally.
- Assert reset during the DAT_HI of bit 3 -> pie_out=1 and busy=0 immediately (asynchronously); the following frame is bit-exact.
- start pulsed while busy, and start with preamble toggled mid-frame -> no effect on the waveform. Preamble choice stays as latched.
- Back-to-back: start asserted in the cycle after done -> the new delimiter begins with no extra idle cycle. The 16-bit random payload matches a reference PIE model cycle for cycle.
